// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and helpers for the round-robin lock arbiter family.
package rr_lock_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    localparam int DEFAULT_MAX_HOLD = 16;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_lock_arbiter_rr_pick.sv
// Combinational rotating-priority picker: double-width masked priority encoder
// starting at ptr, with an optional single-index mask-out.
module rr_pick
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic [IW-1:0] mask_idx,
    input  logic          mask_en,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [N-1:0]   masked;
    logic [2*N-1:0] dbl;

    always_comb begin
        masked = '0;
        for (int i = 0; i < N; i++) begin
            masked[i] = req[i] & ~(mask_en && (mask_idx == IW'(i)));
        end
    end

    // Lower copy only counts from ptr upward; upper copy supplies the wrap.
    always_comb begin
        dbl = '0;
        for (int j = 0; j < 2*N; j++) begin
            dbl[j] = masked[j % N] && ((j >= N) || (j >= int'(ptr)));
        end
    end

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int j = 0; j < 2*N; j++) begin
            if (dbl[j] && !found) begin
                found = 1'b1;
                idx   = IW'(j % N);
            end
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            onehot[i] = found && (idx == IW'(i));
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Registered round-robin arbiter; the grant is locked until the owner releases.
// Optional forced release after MAX_HOLD owned cycles: define RR_LOCK_ARB_TIMEOUT_EN.
// state | meaning
// IDLE  | no owner, grant=0, arbitrate ptr-first against req
// OWNED | grant held by own until release, then re-arbitrate from own+1
module rr_lock_arbiter
    import rr_lock_arbiter_pkg::*;
#(
    parameter int N        = 4,
    parameter int IW       = idx_w(N),
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          busy,
    output logic          timeout
);

    arb_state_t    state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] pick_ptr;
    logic          rel_normal;
    logic          forced;
    logic          release_now;
    logic          grant_load;
    logic          mask_en;
    logic [N-1:0]  pick_onehot;
    logic [IW-1:0] pick_idx;
    logic          found;

    assign nxt_ptr     = (int'(grant_idx) == N-1) ? '0 : grant_idx + IW'(1);
    assign rel_normal  = (state == OWNED) && (!req[grant_idx] || last[grant_idx]);
    assign release_now = rel_normal || forced;
    assign pick_ptr    = (state == OWNED) ? nxt_ptr : ptr;
    assign mask_en     = (state == OWNED) && (!req[grant_idx] || forced);
    assign grant_load  = found && ((state == IDLE) || release_now);

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req      (req),
        .ptr      (pick_ptr),
        .mask_idx (grant_idx),
        .mask_en  (mask_en),
        .onehot   (pick_onehot),
        .idx      (pick_idx),
        .found    (found)
    );

`ifdef RR_LOCK_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);
    logic [HW-1:0] hold_cnt;

    // Normal release wins over a coincident forced one.
    assign forced = (state == OWNED) && !rel_normal && (hold_cnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= forced;
            if (grant_load)
                hold_cnt <= '0;
            else if (state == OWNED)
                hold_cnt <= hold_cnt + HW'(1);
        end
    end
`else
    assign forced  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= OWNED;
                        grant     <= pick_onehot;
                        grant_idx <= pick_idx;
                        busy      <= 1'b1;
                    end
                end
                OWNED: begin
                    if (release_now) begin
                        ptr <= nxt_ptr;
                        if (found) begin
                            grant     <= pick_onehot;
                            grant_idx <= pick_idx;
                        end else begin
                            state     <= IDLE;
                            grant     <= '0;
                            grant_idx <= '0;
                            busy      <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed self-checking bench for rr_lock_arbiter (N=4, MAX_HOLD=4).
module tb_rr_lock_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] last;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    int vectors     = 0;
    int miscompares = 0;

    rr_lock_arbiter #(.N(4), .IW(2), .MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .last      (last),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; last = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({grant, grant_idx, busy, timeout} !== 8'b0000_00_0_0) begin
            miscompares++;
            $display("FAIL reset_state: got %b exp %b", {grant, grant_idx, busy, timeout}, 8'b0);
        end
        for (int i = 0; i < 5; i++) begin
            last = (i >= 3) ? 4'b1111 : 4'b0000;
            step();
            vectors++;
            if ({grant, grant_idx, busy, timeout} !== 8'b0000_00_0_0) begin
                miscompares++;
                $display("FAIL idle_%0d: got %b exp %b", i, {grant, grant_idx, busy, timeout}, 8'b0);
            end
        end
        last = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_grant2: got %b exp %b", {grant, grant_idx, busy}, {4'b0100, 2'd2, 1'b1});
        end
        last = 4'b0100;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_regrant2: got %b exp %b", {grant, grant_idx, busy}, {4'b0100, 2'd2, 1'b1});
        end
        last = '0; req = 4'b1111; rst = 1'b1;
        step();
        vectors++;
        if ({grant, grant_idx, busy, timeout} !== 8'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got %b exp %b", {grant, grant_idx, busy, timeout}, 8'b0);
        end
        rst = 1'b0;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL mid_ptr_cleared: got %b exp %b", {grant, grant_idx, busy}, {4'b0001, 2'd0, 1'b1});
        end
    endtask

    task automatic test_handoff();
        do_reset();
        req = 4'b1010;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b0010, 2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL handoff_first: got %b exp %b", {grant, grant_idx, busy}, {4'b0010, 2'd1, 1'b1});
        end
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({grant, grant_idx, busy} !== {4'b0010, 2'd1, 1'b1}) begin
                miscompares++;
                $display("FAIL handoff_hold_%0d: got %b exp %b", i, {grant, grant_idx, busy}, {4'b0010, 2'd1, 1'b1});
            end
        end
        last = 4'b0010;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b1000, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL handoff_switch: got %b exp %b", {grant, grant_idx, busy}, {4'b1000, 2'd3, 1'b1});
        end
        last = '0; req = '0;
        step();
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        do_reset();
        req = 4'b1111;
        step();
        for (int k = 0; k < 8; k++) begin
            exp_g = 4'b0001 << (k % 4);
            vectors++;
            if ({grant, grant_idx} !== {exp_g, 2'(k % 4)}) begin
                miscompares++;
                $display("FAIL rot_%0d_c1: got %b exp %b", k, {grant, grant_idx}, {exp_g, 2'(k % 4)});
            end
            last = '0;
            step();
            vectors++;
            if ({grant, grant_idx} !== {exp_g, 2'(k % 4)}) begin
                miscompares++;
                $display("FAIL rot_%0d_c2: got %b exp %b", k, {grant, grant_idx}, {exp_g, 2'(k % 4)});
            end
            last = exp_g;
            step();
        end
        vectors++;
        if (grant !== 4'b0001) begin
            miscompares++;
            $display("FAIL rot_wrap: got %b exp %b", grant, 4'b0001);
        end
        last = '0; req = '0;
        step();
    endtask

    task automatic test_drop();
        do_reset();
        req = 4'b0100;
        step();
        req = 4'b0001;
        step();
        vectors++;
        if ({grant, grant_idx, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL drop_switch: got %b exp %b", {grant, grant_idx, busy}, {4'b0001, 2'd0, 1'b1});
        end
        vectors++;
        if (dut.ptr !== 2'd3) begin
            miscompares++;
            $display("FAIL drop_ptr: got %0d exp %0d", dut.ptr, 3);
        end
        req = '0;
        step();
        vectors++;
        if ({grant, grant_idx, busy, timeout} !== 8'b0) begin
            miscompares++;
            $display("FAIL drop_idle: got %b exp %b", {grant, grant_idx, busy, timeout}, 8'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0010; last = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if ({grant, grant_idx, busy} !== {4'b0010, 2'd1, 1'b1}) begin
                miscompares++;
                $display("FAIL b2b_%0d: got %b exp %b", i, {grant, grant_idx, busy}, {4'b0010, 2'd1, 1'b1});
            end
        end
        req = '0; last = '0;
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b1001;
        step();
        for (int c = 0; c < 4; c++) begin
            vectors++;
            if ({grant, timeout} !== {4'b0001, 1'b0}) begin
                miscompares++;
                $display("FAIL to_hold_%0d: got %b exp %b", c, {grant, timeout}, {4'b0001, 1'b0});
            end
            step();
        end
`ifdef RR_LOCK_ARB_TIMEOUT_EN
        vectors++;
        if ({grant, grant_idx, timeout} !== {4'b1000, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL to_forced: got %b exp %b", {grant, grant_idx, timeout}, {4'b1000, 2'd3, 1'b1});
        end
        step();
        vectors++;
        if ({grant, grant_idx, timeout} !== {4'b1000, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL to_pulse_end: got %b exp %b", {grant, grant_idx, timeout}, {4'b1000, 2'd3, 1'b0});
        end
`else
        for (int c = 0; c < 6; c++) begin
            vectors++;
            if ({grant, grant_idx, timeout} !== {4'b0001, 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL to_unbounded_%0d: got %b exp %b", c, {grant, grant_idx, timeout}, {4'b0001, 2'd0, 1'b0});
            end
            step();
        end
`endif
        req = '0;
        step();
    endtask

    initial begin
        rst = 1'b1; req = '0; last = '0;
        test_reset();
        test_reset_mid();
        test_handoff();
        test_rotation();
        test_drop();
        test_back_to_back();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rr_lock_arbiter.md
Name: rr_lock_arbiter

Overview:
- Registered round-robin arbiter with grant locking.
- Shares one downstream resource (bus port, memory bank, shared datapath) among N requesters.
- The grant stays with the current owner until that owner signals the end of its transaction. Priority then rotates to the requester after the owner.
- Sits in front of the shared resource, alongside the existing fixed-priority arbiters, for cases where fairness and multi-cycle ownership are required.

Parameters:
- N, 4, number of requesters; N >= 1; need not be a power of two.
- IW, $clog2(N) (min 1), width of grant_idx.
- MAX_HOLD, 16, maximum cycles a single owner may hold the grant. Used only when the optional feature is compiled in; must be >= 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  N  per-requester request; level, held for the whole transaction.
- last  input  N  per-requester end-of-transaction flag; meaningful only with req of the same bit.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_idx  output  IW  binary index of the owner; valid when busy=1, 0 otherwise.
- busy  output  1  registered; 1 when grant is nonzero.
- timeout  output  1  one-cycle pulse on forced release; constant 0 when the feature is compiled out.

Behaviour:
- Reset (rst=1 at a clock edge): grant=0, grant_idx=0, busy=0, timeout=0, ptr=0, state=IDLE. Applies mid-transaction as well: ownership is lost with no release or pointer update.
- State: 2-state FSM (IDLE, OWNED), rotating pointer ptr in 0..N-1, owner index own.
- Pick function: the first index i scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N) with req[i]=1.
- IDLE: if req != 0 at edge t, then from t+1 grant=onehot(pick), grant_idx=pick, busy=1, state=OWNED. If req == 0, stay IDLE with outputs 0.
- Latency: request to grant is exactly 1 cycle when the arbiter is idle.
- OWNED, hold: owner keeps the grant while req[own]=1 and last[own]=0. Other requests are ignored.
- OWNED, release: occurs on an edge where req[own]=0, or req[own]=1 and last[own]=1. On release:
  - ptr <= (own+1) mod N.
  - Re-arbitration happens in the same cycle using the new pointer against the current req, with bit own masked if req[own] dropped.
  - If a winner exists, the grant switches to it at the next cycle with no idle bubble, and state stays OWNED.
  - Otherwise grant=0 and state=IDLE.
- Simultaneous release and owner re-request: if req[own]=1 and last[own]=1 and no other requester is active, the owner is re-granted. Wrap of ptr yields this naturally.
- N=1: ptr is constant 0; grant mirrors ownership of requester 0.
- Invariants: grant is always one-hot or zero; grant is never asserted to a requester whose req was 0 at the granting edge; last without req has no effect.
- Fairness: with all N requesting continuously and each holding K cycles, each requester is granted once every N*K cycles.

Optional Feature:
- Macro RR_LOCK_ARB_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each new grant and increments each OWNED cycle.
  - When the owner has held MAX_HOLD cycles without a release, the next edge forces a release: same ptr advance and same-cycle re-arbitration, with bit own masked out of the pick.
  - timeout pulses high for exactly one cycle, coincident with the changed grant.
  - A normal release on the same edge takes precedence, and no timeout pulse is issued.
- Undefined: no counter logic; timeout tied 0; ownership is unbounded.

Decomposition:
- Shared package/header: FSM state encoding (IDLE=0, OWNED=1), an index-width helper function (clog2 with min 1), and the default MAX_HOLD constant.
- One sub-module: rr_pick. Combinational rotating-priority picker with inputs req[N], ptr[IW], mask-out index and enable. Outputs a one-hot result, an index and a found flag. Implemented as a double-width masked priority encoder. Reused by future arbiters.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> grant=0, busy=0, timeout=0 throughout. Assert rst mid-OWNED -> grant=0 on the next cycle and ptr=0 (next grant to req 0 when req=4'b1111).
- From reset, req=4'b1010 -> grant=4'b0010 after 1 cycle. Hold 3 cycles, then last[1] -> grant=4'b1000 on the next cycle with no bubble, grant_idx=3.
- All four requesting continuously with last pulsed every 2nd owned cycle -> grant order 0,1,2,3,0,… with each held exactly 2 cycles.
- Owner 2 drops req without last while req[0]=1 -> grant=4'b0001 next cycle and ptr=3. Then req=0 -> state IDLE, busy=0.
- Single requester 1 repeatedly asserting last with req held -> re-granted every cycle, grant stays 4'b0010, no gap.
- With RR_LOCK_ARB_TIMEOUT_EN and MAX_HOLD=4: owner 0 holds without last while req[3]=1 -> after 4 owned cycles grant=4'b1000 with a one-cycle timeout pulse. Compiled out: owner 0 holds indefinitely and timeout=0.
